// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, two write ports (port 1 wins) and a busy
// scoreboard; writes land on the next edge, optionally bypassed same-cycle; no backpressure.
module regfile_sb #(
    parameter int WIDTH     = 32,
    parameter int AW        = 5,
    parameter int INIT_MODE = 1,
    parameter int ZERO_R0   = 1,
    parameter int BYPASS    = 1
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [AW-1:0]    regA,
    input  logic [AW-1:0]    regB,
    output logic [WIDTH-1:0] Adat,
    output logic [WIDTH-1:0] Bdat,
    output logic             Abusy,
    output logic             Bbusy,
    input  logic [AW-1:0]    regW0,
    input  logic [AW-1:0]    regW1,
    input  logic [WIDTH-1:0] Wdat0,
    input  logic [WIDTH-1:0] Wdat1,
    input  logic             RegWrite0,
    input  logic             RegWrite1,
    input  logic             Issue,
    input  logic [AW-1:0]    regD,
    output logic [AW:0]      busy_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] set_vec, clr_vec;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we0, we1, iss;
    logic             n_set;
    logic [1:0]       n_clr;
    logic             hit_a0, hit_a1, hit_b0, hit_b1;

    function automatic logic [WIDTH-1:0] reset_val(input int i);
        if (ZERO_R0 != 0 && i == 0) return '0;
        if (INIT_MODE != 0) return WIDTH'(i);
        return '0;
    endfunction

    // Register 0 is hard-wired when ZERO_R0 is set, so its writes and issues never take effect.
    assign we0 = RegWrite0 && !(ZERO_R0 != 0 && regW0 == '0);
    assign we1 = RegWrite1 && !(ZERO_R0 != 0 && regW1 == '0);
    assign iss = Issue && !(ZERO_R0 != 0 && regD == '0);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (we0) clr_vec[regW0] = 1'b1;
        if (we1) clr_vec[regW1] = 1'b1;
        if (iss) set_vec[regD] = 1'b1;
        busy_d = (busy_q & ~clr_vec) | set_vec;

        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (we0) mem_d[regW0] = Wdat0;
        if (we1) mem_d[regW1] = Wdat1;

        // At most one bit can be newly set and at most two newly cleared per cycle.
        n_set = iss && !busy_q[regD];
        n_clr = '0;
        if (we0 && busy_q[regW0] && !set_vec[regW0]) n_clr = n_clr + 2'd1;
        if (we1 && busy_q[regW1] && !set_vec[regW1] && !(we0 && regW0 == regW1))
            n_clr = n_clr + 2'd1;
        cnt_d = cnt_q + CW'(n_set) - CW'(n_clr);
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= reset_val(i);
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        hit_a0 = (BYPASS != 0) && we0 && (regW0 == regA);
        hit_a1 = (BYPASS != 0) && we1 && (regW1 == regA);
        hit_b0 = (BYPASS != 0) && we0 && (regW0 == regB);
        hit_b1 = (BYPASS != 0) && we1 && (regW1 == regB);

        if (ZERO_R0 != 0 && regA == '0) Adat = '0;
        else if (hit_a1)                Adat = Wdat1;
        else if (hit_a0)                Adat = Wdat0;
        else                            Adat = mem_q[regA];

        if (ZERO_R0 != 0 && regB == '0) Bdat = '0;
        else if (hit_b1)                Bdat = Wdat1;
        else if (hit_b0)                Bdat = Wdat0;
        else                            Bdat = mem_q[regB];

        Abusy = busy_q[regA] && !(hit_a0 || hit_a1);
        Bbusy = busy_q[regB] && !(hit_b0 || hit_b1);
    end

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus,
// expectations are queued with a target cycle and checked by a negedge monitor.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        Rst;
    logic [4:0]  regA, regB, regW0, regW1, regD;
    logic [31:0] Wdat0, Wdat1;
    logic        RegWrite0, RegWrite1, Issue;
    logic [31:0] Adat, Bdat, nb_Adat, nb_Bdat;
    logic        Abusy, Bbusy, nb_Abusy, nb_Bbusy;
    logic [5:0]  busy_cnt, nb_cnt;

    int cycle   = 0;
    int n_check = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    regfile_sb dut (
        .clk(clk), .Rst(Rst), .regA(regA), .regB(regB), .Adat(Adat), .Bdat(Bdat),
        .Abusy(Abusy), .Bbusy(Bbusy), .regW0(regW0), .regW1(regW1), .Wdat0(Wdat0),
        .Wdat1(Wdat1), .RegWrite0(RegWrite0), .RegWrite1(RegWrite1), .Issue(Issue),
        .regD(regD), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .Rst(Rst), .regA(regA), .regB(regB), .Adat(nb_Adat), .Bdat(nb_Bdat),
        .Abusy(nb_Abusy), .Bbusy(nb_Bbusy), .regW0(regW0), .regW1(regW1), .Wdat0(Wdat0),
        .Wdat1(Wdat1), .RegWrite0(RegWrite0), .RegWrite1(RegWrite1), .Issue(Issue),
        .regD(regD), .busy_cnt(nb_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    localparam int S_ADAT = 0, S_BDAT = 1, S_ABUSY = 2, S_BBUSY = 3, S_CNT = 4;
    localparam int S_NB_ADAT = 5, S_NB_ABUSY = 6, S_NB_CNT = 7;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_ADAT:     return Adat;
            S_BDAT:     return Bdat;
            S_ABUSY:    return {31'd0, Abusy};
            S_BBUSY:    return {31'd0, Bbusy};
            S_CNT:      return {26'd0, busy_cnt};
            S_NB_ADAT:  return nb_Adat;
            S_NB_ABUSY: return {31'd0, nb_Abusy};
            default:    return {26'd0, nb_cnt};
        endcase
    endfunction

    // dly = 0: check in the current cycle; dly = 1: check after the next edge.
    task automatic expect_at(input string nm, input int sel, input logic [31:0] e, input int dly);
        exp_t x;
        x.name = nm;
        x.sel  = sel;
        x.exp  = e;
        x.cyc  = cycle + dly;
        sb_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cycle) begin
                logic [31:0] act;
                n_check++;
                if (sb_q[i].cyc < cycle) begin
                    n_fail++;
                    $display("FAIL %s: check missed its cycle %0d (now %0d)",
                             sb_q[i].name, sb_q[i].cyc, cycle);
                end else begin
                    act = sample(sb_q[i].sel);
                    if (act !== sb_q[i].exp) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                                 sb_q[i].name, act, sb_q[i].exp, cycle);
                    end
                end
                sb_q.delete(i);
            end
        end
    end

    initial begin
        Rst = 1'b1;
        regA = '0; regB = '0; regW0 = '0; regW1 = '0; regD = '0;
        Wdat0 = '0; Wdat1 = '0;
        RegWrite0 = 1'b0; RegWrite1 = 1'b0; Issue = 1'b0;
        step();
        step();

        // Some activity, then reset mid-run.
        Rst = 1'b0;
        Issue = 1'b1; regD = 5'd7;
        RegWrite0 = 1'b1; regW0 = 5'd7; Wdat0 = 32'h777;
        step();
        Issue = 1'b0; RegWrite0 = 1'b0;
        expect_at("pre_rst_cnt", S_CNT, 32'd1, 0);
        step();
        Rst = 1'b1; regA = 5'd7; regB = 5'd31;
        expect_at("rst_adat_r7", S_ADAT, 32'd7, 0);
        expect_at("rst_bdat_r31", S_BDAT, 32'd31, 0);
        expect_at("rst_cnt", S_CNT, 32'd0, 0);
        expect_at("rst_abusy", S_ABUSY, 32'd0, 0);
        step();
        Rst = 1'b0;

        // Write r3, then an async reset pulse between edges restores it.
        RegWrite0 = 1'b1; regW0 = 5'd3; Wdat0 = 32'd5; regA = 5'd3;
        expect_at("byp_r3", S_ADAT, 32'd5, 0);
        step();
        RegWrite0 = 1'b0;
        expect_at("arr_r3", S_ADAT, 32'd5, 0);
        step();
        Rst = 1'b1;
        #2;
        Rst = 1'b0;
        expect_at("async_rst_r3", S_ADAT, 32'd3, 0);
        step();

        // Dual write to r4: port 1 wins.
        RegWrite0 = 1'b1; regW0 = 5'd4; Wdat0 = 32'hAAAA;
        RegWrite1 = 1'b1; regW1 = 5'd4; Wdat1 = 32'h5555;
        regA = 5'd4;
        expect_at("dual_byp_r4", S_ADAT, 32'h5555, 0);
        expect_at("dual_nb_old_r4", S_NB_ADAT, 32'd4, 0);
        step();
        RegWrite0 = 1'b0; RegWrite1 = 1'b0;
        expect_at("dual_arr_r4", S_ADAT, 32'h5555, 0);
        expect_at("dual_nb_r4", S_NB_ADAT, 32'h5555, 0);
        step();

        // Register 0 ignores writes and issues.
        RegWrite0 = 1'b1; regW0 = 5'd0; Wdat0 = 32'hFFFF;
        Issue = 1'b1; regD = 5'd0; regA = 5'd0;
        expect_at("r0_byp", S_ADAT, 32'd0, 0);
        expect_at("r0_busy_now", S_ABUSY, 32'd0, 0);
        expect_at("r0_cnt_now", S_CNT, 32'd0, 0);
        step();
        RegWrite0 = 1'b0; Issue = 1'b0;
        expect_at("r0_arr", S_ADAT, 32'd0, 0);
        expect_at("r0_busy", S_ABUSY, 32'd0, 0);
        expect_at("r0_cnt", S_CNT, 32'd0, 0);
        step();

        // Scoreboard: issue r5, r6, r5 again, then write r5.
        Issue = 1'b1; regD = 5'd5;
        expect_at("sb_cnt_1", S_CNT, 32'd1, 1);
        step();
        regD = 5'd6;
        expect_at("sb_cnt_2", S_CNT, 32'd2, 1);
        step();
        regD = 5'd5;
        expect_at("sb_cnt_2_again", S_CNT, 32'd2, 1);
        step();
        Issue = 1'b0;
        RegWrite0 = 1'b1; regW0 = 5'd5; Wdat0 = 32'h55;
        regA = 5'd5; regB = 5'd6;
        expect_at("sb_abusy_clr_byp", S_ABUSY, 32'd0, 0);
        expect_at("sb_adat_byp", S_ADAT, 32'h55, 0);
        expect_at("sb_bbusy_r6", S_BBUSY, 32'd1, 0);
        expect_at("sb_cnt_after_clr", S_CNT, 32'd1, 1);
        step();
        RegWrite0 = 1'b0;

        // Simultaneous issue and write of r8: data lands, busy stays set.
        Issue = 1'b1; regD = 5'd8;
        RegWrite0 = 1'b1; regW0 = 5'd8; Wdat0 = 32'h12;
        regA = 5'd8;
        expect_at("sc_cnt", S_CNT, 32'd2, 1);
        expect_at("sc_abusy", S_ABUSY, 32'd1, 1);
        expect_at("sc_adat", S_ADAT, 32'h12, 1);
        step();
        Issue = 1'b0; RegWrite0 = 1'b0;
        step();

        // Non-bypass instance: data and busy clear appear one cycle later.
        RegWrite0 = 1'b1; regW0 = 5'd2; Wdat0 = 32'h99; regA = 5'd2;
        expect_at("nb_old_r2", S_NB_ADAT, 32'd2, 0);
        expect_at("byp_new_r2", S_ADAT, 32'h99, 0);
        expect_at("nb_new_r2", S_NB_ADAT, 32'h99, 1);
        step();
        RegWrite0 = 1'b0;
        Issue = 1'b1; regD = 5'd9;
        step();
        Issue = 1'b0;
        RegWrite0 = 1'b1; regW0 = 5'd9; Wdat0 = 32'h1; regA = 5'd9;
        expect_at("nb_abusy_still", S_NB_ABUSY, 32'd1, 0);
        expect_at("byp_abusy_clr", S_ABUSY, 32'd0, 0);
        expect_at("cnt_r9_busy", S_CNT, 32'd3, 0);
        expect_at("nb_abusy_clr", S_NB_ABUSY, 32'd0, 1);
        step();
        RegWrite0 = 1'b0;
        expect_at("final_cnt", S_CNT, 32'd2, 1);
        expect_at("final_nb_cnt", S_NB_CNT, 32'd2, 1);
        step();
        step();
        step();

        foreach (sb_q[i]) begin
            n_check++;
            n_fail++;
            $display("FAIL %s: never checked (due cycle %0d)", sb_q[i].name, sb_q[i].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
